// File: rtl/pipeline_ctrl.sv
// Stall/bubble/redirect sequencer for the 5-stage core: merges hazard and bus-wait
// sources into per-stage enables, bubble injects and a next-PC override.
module pipeline_ctrl #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_use,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic             if_busy,
  input  logic             mem_busy,
  output logic             f_en,
  output logic             d_en,
  output logic             e_en,
  output logic             m_en,
  output logic             w_en,
  output logic             d_bubble,
  output logic             e_bubble,
  output logic             w_bubble,
  output logic             pc_sel,
  output logic [PC_W-1:0]  pc_target,
  output logic             pend,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             err
);
  typedef enum logic {RUN = 1'b0, REDIR_PEND = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t          state, state_nxt;
  logic [PC_W-1:0] tgt_q, tgt_nxt;
  logic            err_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      tgt_q <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      tgt_q <= tgt_nxt;
      err   <= err_nxt;
    end
  end

  // Strict priority: D-bus wait > load-use > I-bus wait > free-running.
  always_comb begin
    f_en      = 1'b0;
    d_en      = 1'b0;
    e_en      = 1'b0;
    m_en      = 1'b0;
    w_en      = 1'b0;
    d_bubble  = 1'b0;
    e_bubble  = 1'b0;
    w_bubble  = 1'b0;
    pc_sel    = 1'b0;
    state_nxt = state;
    tgt_nxt   = tgt_q;
    pc_target = (state == REDIR_PEND) ? tgt_q : redirect_pc;
    if (reset) begin
      pc_target = '0;
    end else if (mem_busy) begin
      w_en     = 1'b1;
      w_bubble = 1'b1;
    end else if (ld_use) begin
      e_en     = 1'b1;
      m_en     = 1'b1;
      w_en     = 1'b1;
      e_bubble = 1'b1;
    end else if (if_busy) begin
      d_en     = 1'b1;
      e_en     = 1'b1;
      m_en     = 1'b1;
      w_en     = 1'b1;
      d_bubble = 1'b1;
      // Delay-slot fetch still outstanding: park the target until it lands.
      if (state == RUN && redirect) begin
        tgt_nxt   = redirect_pc;
        state_nxt = REDIR_PEND;
      end
    end else begin
      f_en = 1'b1;
      d_en = 1'b1;
      e_en = 1'b1;
      m_en = 1'b1;
      w_en = 1'b1;
      if (state == REDIR_PEND) begin
        pc_sel    = 1'b1;
        state_nxt = RUN;
      end else if (redirect) begin
        pc_sel = 1'b1;
      end
    end
  end

  // A redirect while parked means decode issued from a bubble slot: flag it, keep tgt_q.
  assign err_nxt = err | (state == REDIR_PEND && redirect);
  assign pend    = (state == REDIR_PEND);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (!f_en && stall_cnt != '1)
      stall_cnt <= stall_cnt + CNT_ONE;
  end
endmodule
